// File: rtl/serial_addsub_if.sv
// Serial add/subtract bit stream: operand bits in, result bits and word status out.
interface serial_addsub_if;
  logic QEN, START, OP, A, B;
  logic DZ, DV, CO, ZF, DONE;

  modport master (output QEN, START, OP, A, B, input DZ, DV, CO, ZF, DONE);
  modport slave  (input QEN, START, OP, A, B, output DZ, DV, CO, ZF, DONE);
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial LSB-first adder/subtractor with a single carry/borrow flop;
// reports final carry/borrow and a zero flag one cycle after each word's MSB.
module serial_addsub #(
  parameter int WIDTH      = 8,
  parameter     OP_DEFAULT = "ADD"
) (
  input  logic            QCK,
  input  logic            QRTN,
  serial_addsub_if.slave  bus
);
  localparam int             CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST   = CW'(WIDTH - 1);
  localparam logic           OP_RST = (OP_DEFAULT == "SUB");

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          c_q, c_d, z_q, z_d, op_q, op_d;
  logic          dz_q, dv_q, co_q, zf_q, done_q;

  logic accept, last, op_eff, c_in, z_in, sum, c_nxt, z_nxt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    z_d     = z_q;
    op_d    = op_q;
    accept  = bus.QEN & (bus.START | (state_q == RUN));
    // A START bit always opens a fresh word: new op, no carry-in, zero flag re-armed.
    op_eff  = bus.START ? bus.OP : op_q;
    c_in    = bus.START ? 1'b0   : c_q;
    z_in    = bus.START | z_q;
    sum     = bus.A ^ bus.B ^ c_in;
    c_nxt   = op_eff ? ((~bus.A & bus.B) | (~(bus.A ^ bus.B) & c_in))
                     : ((bus.A & bus.B) | (bus.A & c_in) | (bus.B & c_in));
    z_nxt   = z_in & ~sum;
    last    = bus.START ? (WIDTH == 1) : (cnt_q == LAST);
    if (accept) begin
      op_d = op_eff;
      c_d  = c_nxt;
      z_d  = z_nxt;
      if (last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = RUN;
        cnt_d   = bus.START ? CW'(1) : cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge QCK or negedge QRTN) begin
    if (!QRTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      op_q    <= OP_RST;
      dz_q    <= 1'b0;
      dv_q    <= 1'b0;
      co_q    <= 1'b0;
      zf_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      z_q     <= z_d;
      op_q    <= op_d;
      dv_q    <= accept;
      done_q  <= accept & last;
      if (accept) dz_q <= sum;
      if (accept & last) begin
        co_q <= c_nxt;
        zf_q <= z_nxt;
      end
    end
  end

  assign bus.DZ   = dz_q;
  assign bus.DV   = dv_q;
  assign bus.CO   = co_q;
  assign bus.ZF   = zf_q;
  assign bus.DONE = done_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: word-level arithmetic model feeds queues
// that a negedge monitor drains whenever DV or DONE appears.
module tb_serial_addsub;
  localparam int W = 8;

  logic QCK = 1'b0;
  logic QRTN;
  serial_addsub_if bus();

  serial_addsub #(.WIDTH(W), .OP_DEFAULT("ADD")) dut (
    .QCK  (QCK),
    .QRTN (QRTN),
    .bus  (bus)
  );

  always #5 QCK = ~QCK;

  typedef struct { bit co; bit zf; } done_t;

  int    errors = 0, checks = 0;
  bit    bitq[$];
  done_t doneq[$];
  bit    exp_dv = 0, exp_done = 0, hold_co = 0, hold_zf = 0, mon_on = 0;
  int    stall_at[W];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: cycle-exact DV/DONE presence, then pop and compare payloads.
  always @(negedge QCK) begin
    if (mon_on) begin
      chk("dv_timing", bus.DV, exp_dv);
      chk("done_timing", bus.DONE, exp_done);
      if (bus.DV) begin
        if (bitq.size() == 0) chk("dz_underflow", 1'b1, 1'b0);
        else chk("dz", bus.DZ, bitq.pop_front());
      end
      if (bus.DONE) begin
        if (doneq.size() == 0) chk("done_underflow", 1'b1, 1'b0);
        else begin
          done_t d;
          d = doneq.pop_front();
          hold_co = d.co;
          hold_zf = d.zf;
        end
      end
      chk("co", bus.CO, hold_co);
      chk("zf", bus.ZF, hold_zf);
    end
  end

  task automatic cyc(input bit en, st, op, a, b, dv, dn);
    bus.QEN = en; bus.START = st; bus.OP = op; bus.A = a; bus.B = b;
    @(posedge QCK);
    #1;
    exp_dv   = dv;
    exp_done = dn;
  endtask

  task automatic stall(input int n);
    for (int k = 0; k < n; k++)
      cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
  endtask

  // Ignored bits: only legal when the DUT is idle (after a completed word).
  task automatic idle_bits(input int n);
    for (int k = 0; k < n; k++)
      cyc(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
  endtask

  // Send nbits of a word (nbits < W leaves it abandoned); model is plain integer math.
  task automatic word(input logic [W-1:0] a, input logic [W-1:0] b, input bit op,
                      input int nbits, input bit rnd);
    int ai, bi, r;
    logic [W-1:0] res;
    done_t d;
    ai = int'(a); bi = int'(b);
    r  = op ? ai - bi : ai + bi;
    res  = r[W-1:0];
    d.co = op ? (ai < bi) : (r >= (1 << W));
    d.zf = (res == '0);
    for (int i = 0; i < nbits; i++) begin
      bit lst;
      int ns;
      lst = (nbits == W) && (i == W - 1);
      bitq.push_back(res[i]);
      if (lst) doneq.push_back(d);
      cyc(1'b1, i == 0, (i == 0) ? op : 1'($urandom), a[i], b[i], 1'b1, lst);
      ns = rnd ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0) : stall_at[i];
      stall(ns);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < W; i++) stall_at[i] = 0;
    QRTN = 1'b0;
    bus.QEN = 0; bus.START = 0; bus.OP = 0; bus.A = 0; bus.B = 0;
    #1;
    chk("rst_dz", bus.DZ, 1'b0);
    chk("rst_dv", bus.DV, 1'b0);
    chk("rst_co", bus.CO, 1'b0);
    chk("rst_zf", bus.ZF, 1'b0);
    chk("rst_done", bus.DONE, 1'b0);
    @(negedge QCK);
    QRTN = 1'b1;
    mon_on = 1;

    word(8'h5A, 8'h3C, 1'b0, W, 1'b0);
    idle_bits(2);
    word(8'h10, 8'h20, 1'b1, W, 1'b0);
    word(8'h3C, 8'h3C, 1'b1, W, 1'b0);
    stall(1);

    stall_at[2] = 3; stall_at[5] = 1;
    word(8'hFF, 8'h01, 1'b0, W, 1'b0);
    stall_at[2] = 0; stall_at[5] = 0;

    word(8'h12, 8'h34, 1'b0, 5, 1'b0);
    word(8'h01, 8'h01, 1'b0, W, 1'b0);

    word(8'h80, 8'h80, 1'b0, W, 1'b0);
    word(8'h00, 8'h01, 1'b1, W, 1'b0);

    // Mid-word async reset after a word that left CO=1.
    word(8'h80, 8'h80, 1'b0, W, 1'b0);
    stall(2);
    word(8'h05, 8'h07, 1'b0, 3, 1'b0);
    #2 QRTN = 1'b0;
    #1;
    chk("mrst_dz", bus.DZ, 1'b0);
    chk("mrst_dv", bus.DV, 1'b0);
    chk("mrst_co", bus.CO, 1'b0);
    chk("mrst_zf", bus.ZF, 1'b0);
    chk("mrst_done", bus.DONE, 1'b0);
    exp_dv = 0; exp_done = 0; hold_co = 0; hold_zf = 0;
    bitq.delete(); doneq.delete();
    @(negedge QCK);
    #2 QRTN = 1'b1;
    word(8'h0F, 8'h01, 1'b0, W, 1'b0);

    for (int n = 0; n < 40; n++) begin
      bit ab;
      ab = ($urandom_range(0, 5) == 0);
      word(W'($urandom), W'($urandom), 1'($urandom), ab ? int'($urandom_range(1, W - 1)) : W, 1'b1);
      if (!ab && $urandom_range(0, 2) == 0) idle_bits(int'($urandom_range(1, 2)));
    end
    stall(3);
    chk("bitq_drained", bitq.size() == 0, 1'b1);
    chk("doneq_drained", doneq.size() == 0, 1'b1);
    mon_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial add/subtract cell built on the logic-cell fabric (full adder plus carry/borrow flip-flop).
- Consumes two LSB-first operand streams and produces an LSB-first result stream.
- At word end it reports the final carry or borrow and a zero flag.
- Complements the parallel registered-adder cell: arithmetic runs over WIDTH cycles instead of a carry chain, and subtraction is supported.

Parameters:
WIDTH, 8, bits per operand word (2..32).
OP_DEFAULT, "ADD", operation used when OP is unsampled after reset; "ADD" or "SUB".

Ports:
QCK  input  1  clock, rising edge.
QRTN  input  1  asynchronous active-low reset.
QEN  input  1  bit-valid/enable; a bit is accepted only when QEN=1.
START  input  1  marks the accepted bit as the LSB of a new word.
OP  input  1  0=add, 1=subtract (A-B); sampled only on a START bit.
A  input  1  operand A serial bit.
B  input  1  operand B serial bit.
DZ  output  1  result bit, registered.
DV  output  1  DZ valid strobe.
CO  output  1  final carry (add) or borrow (sub) of the last completed word.
ZF  output  1  1 if every result bit of the last completed word was 0.
DONE  output  1  one-cycle pulse when CO/ZF update.

Behaviour:
- Reset (QRTN=0, asynchronous):
  - DZ=0, DV=0, CO=0, ZF=0, DONE=0.
  - Carry/borrow register=0, bit counter=0, op register=OP_DEFAULT, state=IDLE.
  - Reset released synchronously to QCK in effect: the first accept is possible on the first rising edge with QRTN=1.
- States:
  - IDLE: waiting for START.
  - RUN: word in progress.
- Accept condition: QEN=1 and (START=1 or state=RUN). All other cycles are stalls: DV=0 and internal state holds.
- START accepted (any state):
  - op register<=OP; carry/borrow input for this bit forced to 0; counter<=1.
  - If WIDTH>1, state<=RUN.
- Per-bit arithmetic, using c = stored carry/borrow (0 on START bits):
  - ADD: DZ=A^B^c; c'=(A&B)|(A&c)|(B&c).
  - SUB: DZ=A^B^c; c'=(~A&B)|(~(A^B)&c).
  - Zero accumulator: z' = (START ? 1 : z) & ~DZ.
- Latency: DZ and DV are registered with one cycle of latency. DV=1 exactly in the cycle after each accepted bit.
- Word end, on the accepted bit with counter=WIDTH-1 (or the START bit if WIDTH=1):
  - Next cycle: DONE=1, CO=c', ZF=z', state<=IDLE, counter<=0.
  - CO and ZF hold until the next DONE or reset.
  - DONE coincides with DV of the MSB.
- IDLE with QEN=1 and START=0: bit ignored, no DV.
- START accepted while in RUN: the current word is abandoned and restarted with the new bit as LSB. No DONE for the abandoned word; CO/ZF unchanged.
- Back-to-back words: START on the cycle immediately after the MSB is accepted, giving a gapless stream. DONE of the old word and DV of the new LSB may appear in consecutive cycles.
- QEN=0 mid-word: a stall of any length; counter, carry and op all held.
- Reset mid-word: word discarded, outputs cleared immediately.
- OP changes while in RUN are ignored.

Test Plan:
- WIDTH=8, ADD, A=0x5A, B=0x3C, continuous QEN -> DZ stream 0x96 LSB-first over 8 DV cycles; DONE with CO=0, ZF=0 one cycle after the MSB.
- SUB, A=0x10, B=0x20 -> DZ=0xF0, CO(borrow)=1, ZF=0. SUB, A=0x3C, B=0x3C -> DZ=0x00, CO=0, ZF=1.
- ADD, A=0xFF, B=0x01 with QEN=0 for 3 cycles after bit 2 and 1 cycle after bit 5 -> DZ=0x00, CO=1, ZF=1; DV absent during stalls; DONE 1 cycle after the MSB is accepted.
- Re-START after bit 4 of a word (A=0x12, B=0x34), then a full word A=0x01, B=0x01 ADD -> no DONE for the first word; second word gives DZ=0x02, CO=0, ZF=0.
- Two gapless words (ADD 0x80+0x80, then SUB 0x00-0x01) -> DONE with CO=1, ZF=1 after word 1, then DONE with CO=1, ZF=0 and DZ=0xFF after word 2.
- Assert QRTN=0 asynchronously mid-word after a completed word left CO=1 -> all outputs 0 immediately, no DONE; a following word computes correctly with a fresh carry.
